// File: rtl/multi_ctrl_pkg.sv
// multi_ctrl_pkg: shared types and constants for the multi-cycle CPU control.
//   state_t      - control FSM state encoding (ADDI states only when
//                  MULTI_CTRL_ADDI_EN is defined)
//   OP_*         - opcode values (inst[31:26])
//   FUNCT_*      - R-type funct values (inst[5:0])
//   ALU_*        - alu_ctrl_sig codes
//   SRCB_*       - alu_srcB select values
//   ALUOP_*      - coarse ALU request passed to alu_decoder
package multi_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MULTI_CTRL_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multi_ctrl_if.sv
// ctrl_bus_if: clock and reset bundle for the multi-cycle control block.
//   clk - single system clock
//   rst - synchronous, active-low reset
// Modports: central (consumer, used by multi_ctrl), driver (clock/reset source).
interface ctrl_bus_if;
    logic clk;
    logic rst;

    modport central (input clk, input rst);
    modport driver  (output clk, output rst);
endinterface

// File: rtl/multi_ctrl_alu_decoder.sv
// alu_decoder: combinational ALU control decode.
//   aluop_i     - 00 add, 01 sub, 10 decode from funct (11 treated as add)
//   funct_i     - R-type funct field
//   alu_ctrl_o  - ALU operation code
//   funct_bad_o - funct decode requested but funct is not supported
module alu_decoder
    import multi_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_bad_o
);

    always_comb begin
        alu_ctrl_o  = ALU_ADD;
        funct_bad_o = 1'b0;
        case (aluop_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_ctrl_o = ALU_ADD;
                    FUNCT_SUB: alu_ctrl_o = ALU_SUB;
                    FUNCT_AND: alu_ctrl_o = ALU_AND;
                    FUNCT_OR:  alu_ctrl_o = ALU_OR;
                    FUNCT_SLT: alu_ctrl_o = ALU_SLT;
                    // Unknown funct still executes as add, but is flagged.
                    default: begin
                        alu_ctrl_o  = ALU_ADD;
                        funct_bad_o = 1'b1;
                    end
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// multi_ctrl: main control FSM of the multi-cycle MIPS-subset CPU.
// Moore FSM, one state per cycle; outputs decode from the state, with
// ireg/pc write gated by mem_ready in FETCH and pc write gated by zero in
// BRANCH. Memory-access states hold until mem_ready.
// Optional feature: define MULTI_CTRL_ADDI_EN to add ADDIEX/ADDIWB and execute
// addi; otherwise addi is flagged as illegal.
// Ports:
//   ctrl_bus        - clk, rst (sync, active-low)
//   op, funct       - opcode / funct from the instruction register
//   zero            - ALU zero flag
//   mem_ready       - memory completes the current access this cycle
//   mem_req, mem_write, i_or_d - memory request, write, address select
//   ireg_write_enab, pc_write_enab, pc_src, jmp - IR/PC control
//   alu_srcA, alu_srcB, alu_ctrl_sig            - ALU operand/op selects
//   reg_dst, reg_write, mem_to_reg              - register file control
//   illegal_op      - sticky unsupported opcode/funct flag
//   state_o         - current FSM state (observation)
module multi_ctrl
    import multi_ctrl_pkg::*;
#(
    parameter int N_OP    = 6,
    parameter int N_FUNCT = 6
) (
    ctrl_bus_if.central       ctrl_bus,
    input  logic [N_OP-1:0]    op,
    input  logic [N_FUNCT-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ireg_write_enab,
    output logic               pc_write_enab,
    output logic               pc_src,
    output logic               jmp,
    output logic               alu_srcA,
    output logic [1:0]         alu_srcB,
    output logic [2:0]         alu_ctrl_sig,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output state_t             state_o
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] aluop;
    logic       alu_en;
    logic [2:0] dec_ctrl;
    logic       funct_bad;

    alu_decoder u_alu_decoder (
        .aluop_i     (aluop),
        .funct_i     (funct),
        .alu_ctrl_o  (dec_ctrl),
        .funct_bad_o (funct_bad)
    );

    always_ff @(posedge ctrl_bus.clk) begin
        if (!ctrl_bus.rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`else
                    OP_ADDI: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC: begin
                state_d = S_ALUWB;
                if (funct_bad) illegal_d = 1'b1;
            end
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // ALU request per state; kept apart from the output decode so the
    // decoder result feeds forward without a loop through one block.
    always_comb begin
        aluop  = ALUOP_ADD;
        alu_en = 1'b0;
        case (state_q)
            S_FETCH, S_DECODE, S_MEMADR: alu_en = 1'b1;
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: alu_en = 1'b1;
`endif
            S_EXEC: begin
                alu_en = 1'b1;
                aluop  = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                alu_en = 1'b1;
                aluop  = ALUOP_SUB;
            end
            default: alu_en = 1'b0;
        endcase
    end

    always_comb begin
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        i_or_d          = 1'b0;
        ireg_write_enab = 1'b0;
        pc_write_enab   = 1'b0;
        pc_src          = 1'b0;
        jmp             = 1'b0;
        alu_srcA        = 1'b0;
        alu_srcB        = SRCB_REG;
        alu_ctrl_sig    = alu_en ? dec_ctrl : 3'b000;
        reg_dst         = 1'b0;
        reg_write       = 1'b0;
        mem_to_reg      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req         = 1'b1;
                alu_srcB        = SRCB_FOUR;
                ireg_write_enab = mem_ready;
                pc_write_enab   = mem_ready;
            end
            S_DECODE: alu_srcB = SRCB_BOFF;
            S_MEMADR: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC:  alu_srcA = 1'b1;
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_srcA      = 1'b1;
                pc_src        = 1'b1;
                pc_write_enab = zero;
            end
            S_JUMP: begin
                jmp           = 1'b1;
                pc_write_enab = 1'b1;
            end
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_IMM;
            end
            S_ADDIWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
        // Nothing fires while reset is held, whatever state is latched.
        if (!ctrl_bus.rst) begin
            mem_req         = 1'b0;
            mem_write       = 1'b0;
            i_or_d          = 1'b0;
            ireg_write_enab = 1'b0;
            pc_write_enab   = 1'b0;
            pc_src          = 1'b0;
            jmp             = 1'b0;
            alu_srcA        = 1'b0;
            alu_srcB        = SRCB_REG;
            alu_ctrl_sig    = 3'b000;
            reg_dst         = 1'b0;
            reg_write       = 1'b0;
            mem_to_reg      = 1'b0;
        end
    end

    assign illegal_op = illegal_q;
    assign state_o    = state_q;

endmodule
